// File: rtl/mem_responder.sv
// Memory-side bus responder: loadable program ROM plus data RAM, with one latched
// address per space, auto-increment on data phases, and sticky fault flags.
module mem_responder #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ROM_WORDS = 256,
  parameter int unsigned RAM_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] bus_in,
  input  logic                 rom_ram,
  input  logic                 addr_data,
  output logic [DATA_BITS-1:0] data_out,
  input  logic                 prog_we,
  input  logic [7:0]           prog_addr,
  input  logic [DATA_BITS-1:0] prog_data,
  output logic [7:0]           rom_addr_q,
  output logic [7:0]           ram_addr_q,
  output logic                 rom_wr_fault,
  output logic                 ram_range_fault
);

  localparam int unsigned ROM_AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [8:0]  ROM_LIM = 9'(ROM_WORDS);
  localparam logic [8:0]  RAM_LIM = 9'(RAM_WORDS);

  logic [DATA_BITS-1:0] rom [ROM_WORDS];
  logic [DATA_BITS-1:0] ram [RAM_WORDS];

  logic [7:0]           bus_addr;
  logic [7:0]           rom_rd_addr;
  logic                 rom_rd_ok;
  logic                 ram_rd_ok;
  logic                 ram_wr_ok;
  logic [DATA_BITS-1:0] rom_rd;
  logic [DATA_BITS-1:0] ram_rd;

  // ROM data phases stream from the incremented address, so the read port
  // looks ahead instead of using the latched address directly.
  always_comb begin
    bus_addr    = 8'(bus_in);
    rom_rd_addr = addr_data ? (rom_addr_q + 8'd1) : bus_addr;
    rom_rd_ok   = ({1'b0, rom_rd_addr} < ROM_LIM);
    ram_rd_ok   = ({1'b0, bus_addr} < RAM_LIM);
    ram_wr_ok   = ({1'b0, ram_addr_q} < RAM_LIM);
    rom_rd      = rom_rd_ok ? rom[rom_rd_addr[ROM_AW-1:0]] : '0;
    ram_rd      = ram_rd_ok ? ram[bus_addr[RAM_AW-1:0]] : '0;
  end

  // Program load is independent of reset; reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (prog_we && ({1'b0, prog_addr} < ROM_LIM))
      rom[prog_addr[ROM_AW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && addr_data && rom_ram && ram_wr_ok)
      ram[ram_addr_q[RAM_AW-1:0]] <= bus_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out        <= '0;
      rom_addr_q      <= '0;
      ram_addr_q      <= '0;
      rom_wr_fault    <= 1'b0;
      ram_range_fault <= 1'b0;
    end else if (!addr_data) begin
      if (rom_ram) begin
        ram_addr_q <= bus_addr;
        data_out   <= ram_rd;
        if (!ram_rd_ok) ram_range_fault <= 1'b1;
      end else begin
        rom_addr_q <= bus_addr;
        data_out   <= rom_rd;
      end
    end else begin
      if (rom_ram) begin
        ram_addr_q <= ram_addr_q + 8'd1;
        data_out   <= bus_in;
        if (!ram_wr_ok) ram_range_fault <= 1'b1;
      end else begin
        rom_addr_q   <= rom_rd_addr;
        data_out     <= rom_rd;
        rom_wr_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard queue of expected data_out
// values plus inline checks of address registers and fault flags.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       rom_ram;
  logic       addr_data;
  logic [7:0] data_out;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] rom_addr_q;
  logic [7:0] ram_addr_q;
  logic       rom_wr_fault;
  logic       ram_range_fault;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  mem_responder #(.DATA_BITS(8), .ROM_WORDS(256), .RAM_WORDS(16)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .rom_ram(rom_ram),
    .addr_data(addr_data), .data_out(data_out), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .rom_addr_q(rom_addr_q),
    .ram_addr_q(ram_addr_q), .rom_wr_fault(rom_wr_fault),
    .ram_range_fault(ram_range_fault)
  );

  always #5 clk = ~clk;

  // Drive one bus phase for one edge; when chk is set the expected data_out is
  // queued before the edge and compared after it.
  task automatic step(input logic [7:0] b, input logic rr, input logic ad,
                      input logic chk, input logic [7:0] exp, input string name);
    logic [7:0] e;
    bus_in = b; rom_ram = rr; addr_data = ad;
    if (chk) exp_q.push_back(exp);
    @(posedge clk); #1;
    prog_we = 1'b0;
    if (chk) begin
      e = exp_q.pop_front();
      total++;
      if (data_out !== e) begin
        bad++;
        $display("FAIL %s data_out got=%h exp=%h", name, data_out, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] la[8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd9, 8'd41, 8'd255, 8'd40};
    logic [7:0] ld[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h41, 8'hEE, 8'h40};
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_addr = la[i]; prog_data = ld[i];
      step(8'd3, i[0], 1'b0, 1'b1, 8'h00, "reset_data");
    end
    total++; if (rom_addr_q !== 8'd0) begin bad++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr_q); end
    total++; if (ram_addr_q !== 8'd0) begin bad++; $display("FAIL reset_ram_addr got=%h exp=00", ram_addr_q); end
    total++; if ({rom_wr_fault, ram_range_fault} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b exp=00", {rom_wr_fault, ram_range_fault});
    end
    reset = 1'b0;
  endtask

  task automatic test_rom_stream();
    step(8'd0, 1'b0, 1'b0, 1'b1, 8'h11, "rom_addr0");
    total++; if (rom_wr_fault !== 1'b0) begin bad++; $display("FAIL rom_fault_early got=%b exp=0", rom_wr_fault); end
    step(8'h99, 1'b0, 1'b1, 1'b1, 8'h22, "rom_stream1");
    step(8'h99, 1'b0, 1'b1, 1'b1, 8'h33, "rom_stream2");
    step(8'h99, 1'b0, 1'b1, 1'b1, 8'h44, "rom_stream3");
    total++; if (rom_addr_q !== 8'd3) begin bad++; $display("FAIL rom_addr_q got=%h exp=03", rom_addr_q); end
    total++; if (rom_wr_fault !== 1'b1) begin bad++; $display("FAIL rom_wr_fault got=%b exp=1", rom_wr_fault); end
    total++; if (ram_addr_q !== 8'd0) begin bad++; $display("FAIL ram_addr_untouched got=%h exp=00", ram_addr_q); end
  endtask

  task automatic test_ram_burst();
    step(8'd5, 1'b1, 1'b0, 1'b0, 8'h00, "ram_addr5");
    step(8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, "ram_echo_aa");
    step(8'hBB, 1'b1, 1'b1, 1'b1, 8'hBB, "ram_echo_bb");
    total++; if (ram_addr_q !== 8'd7) begin bad++; $display("FAIL ram_addr_q7 got=%h exp=07", ram_addr_q); end
    step(8'd6, 1'b1, 1'b0, 1'b1, 8'hBB, "ram_read6");
    step(8'd5, 1'b1, 1'b0, 1'b1, 8'hAA, "ram_read5");
    total++; if (ram_range_fault !== 1'b0) begin bad++; $display("FAIL ram_fault_early got=%b exp=0", ram_range_fault); end
    total++; if (rom_addr_q !== 8'd3) begin bad++; $display("FAIL rom_addr_kept got=%h exp=03", rom_addr_q); end
  endtask

  task automatic test_wrap_range();
    step(8'd15, 1'b1, 1'b0, 1'b0, 8'h00, "ram_addr15");
    step(8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, "ram_echo_5a");
    total++; if (ram_addr_q !== 8'd16) begin bad++; $display("FAIL ram_addr_q16 got=%h exp=10", ram_addr_q); end
    total++; if (ram_range_fault !== 1'b0) begin bad++; $display("FAIL ram_fault_at15 got=%b exp=0", ram_range_fault); end
    step(8'h77, 1'b1, 1'b1, 1'b0, 8'h00, "ram_drop_77");
    total++; if (ram_range_fault !== 1'b1) begin bad++; $display("FAIL ram_range_fault got=%b exp=1", ram_range_fault); end
    total++; if (ram_addr_q !== 8'd17) begin bad++; $display("FAIL ram_addr_q17 got=%h exp=11", ram_addr_q); end
    step(8'd15, 1'b1, 1'b0, 1'b1, 8'h5A, "ram_read15");
    step(8'd16, 1'b1, 1'b0, 1'b1, 8'h00, "ram_read16_zero");
    step(8'd255, 1'b1, 1'b0, 1'b1, 8'h00, "ram_read255_zero");
    step(8'h12, 1'b1, 1'b1, 1'b0, 8'h00, "ram_wrap_data");
    total++; if (ram_addr_q !== 8'd0) begin bad++; $display("FAIL ram_wrap got=%h exp=00", ram_addr_q); end
    step(8'd255, 1'b0, 1'b0, 1'b1, 8'hEE, "rom_read255");
    step(8'h00, 1'b0, 1'b1, 1'b1, 8'h11, "rom_wrap_stream");
    total++; if (rom_addr_q !== 8'd0) begin bad++; $display("FAIL rom_wrap got=%h exp=00", rom_addr_q); end
  endtask

  task automatic test_read_before_write();
    prog_we = 1'b1; prog_addr = 8'd9; prog_data = 8'h02;
    step(8'd9, 1'b0, 1'b0, 1'b1, 8'h01, "rbw_old");
    step(8'd9, 1'b0, 1'b0, 1'b1, 8'h02, "rbw_new");
  endtask

  task automatic test_reset_mid();
    step(8'd3, 1'b1, 1'b0, 1'b0, 8'h00, "ram_addr3");
    step(8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, "ram_echo_c3");
    step(8'd3, 1'b1, 1'b0, 1'b1, 8'hC3, "ram_read3");
    reset = 1'b1;
    step(8'd7, 1'b1, 1'b1, 1'b1, 8'h00, "midreset_data");
    total++; if ({rom_addr_q, ram_addr_q} !== 16'h0000) begin
      bad++; $display("FAIL midreset_addrs got=%h exp=0000", {rom_addr_q, ram_addr_q});
    end
    total++; if ({rom_wr_fault, ram_range_fault} !== 2'b00) begin
      bad++; $display("FAIL midreset_flags got=%b exp=00", {rom_wr_fault, ram_range_fault});
    end
    reset = 1'b0;
    step(8'h00, 1'b0, 1'b1, 1'b1, 8'h22, "resume_rom_burst");
    total++; if (rom_addr_q !== 8'd1) begin bad++; $display("FAIL resume_rom_addr got=%h exp=01", rom_addr_q); end
    step(8'd3, 1'b1, 1'b0, 1'b1, 8'hC3, "ram3_kept");
  endtask

  task automatic test_space_indep();
    step(8'd40, 1'b0, 1'b0, 1'b1, 8'h40, "rom_addr40");
    step(8'd2, 1'b1, 1'b0, 1'b0, 8'h00, "ram_addr2");
    total++; if (rom_addr_q !== 8'd40) begin bad++; $display("FAIL rom_addr_stays got=%h exp=28", rom_addr_q); end
    total++; if (ram_addr_q !== 8'd2) begin bad++; $display("FAIL ram_addr2 got=%h exp=02", ram_addr_q); end
    step(8'h00, 1'b0, 1'b1, 1'b1, 8'h41, "rom_read41");
    total++; if (rom_addr_q !== 8'd41) begin bad++; $display("FAIL rom_addr41 got=%h exp=29", rom_addr_q); end
    total++; if (ram_addr_q !== 8'd2) begin bad++; $display("FAIL ram_addr_stays got=%h exp=02", ram_addr_q); end
  endtask

  initial begin
    reset = 1'b1; bus_in = '0; rom_ram = 1'b0; addr_data = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    test_reset();
    test_rom_stream();
    test_ram_burst();
    test_wrap_range();
    test_read_before_write();
    test_reset_mid();
    test_space_indep();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
